irq_controller: RTL and testbench

- Memory-mapped interrupt controller that sits between external interrupt sources and the MIPS core's single `interrupter` input.
- Decodes the core's data-memory bus (mem_ren/mem_wen/mem_addr/mem_dout) for its own 16-byte register window and returns read data for the core's mem_din mux.
- Synchronizes, edge-detects or level-tracks, masks and prioritizes N sources, then drives one registered interrupt request to CP0.
- Software services requests through a claim register with read side effects and a write-1-to-clear pending register.

---
 rtl/irq_controller.sv | 153 +++++++++++++++
 tb/tb_irq_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller
// Memory-mapped interrupt controller that sits in front of the core's single
// interrupt input. Sources are synchronized, then edge-captured or
// level-tracked, masked, and priority-encoded (lowest index wins). Software
// claims the top request through CLAIM and clears edge requests by writing
// 1s to PENDING.

module irq_controller #(
   parameter int unsigned N_SRC     = 8,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             mem_ren,
   input  logic             mem_wen,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   output logic [31:0]      mem_rdata,
   output logic             hit,
   output logic             interrupter,
   output logic [4:0]       irq_id
);

   localparam logic [1:0] OFF_PENDING = 2'd0;
   localparam logic [1:0] OFF_MASK    = 2'd1;
   localparam logic [1:0] OFF_MODE    = 2'd2;
   localparam logic [1:0] OFF_CLAIM   = 2'd3;

   // Zero-extend a per-source vector to a bus word.
   function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
      logic [31:0] r;
      r            = 32'h0000_0000;
      r[N_SRC-1:0] = v;
      return r;
   endfunction

   logic [N_SRC-1:0] s1_r, s2_r, s3_r;
   logic [N_SRC-1:0] pending_r, mask_r, mode_r;
   logic             claim_busy_r;
   logic [N_SRC-1:0] rise_s, active_s, w1c_s, claim_clr_s, pending_nxt_s;
   logic [1:0]       offset_s;
   logic             wr_pend_s, wr_mask_s, wr_mode_s, claim_rd_s, claim_s;
   logic [4:0]       id_nxt_s;
   logic             unused_s;

   // Only the word offset inside the window matters; byte lanes and the
   // upper store-data bits beyond N_SRC are intentionally ignored.
   assign unused_s   = ^{mem_addr[1:0], mem_wdata};

   assign hit        = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign offset_s   = mem_addr[3:2];
   assign wr_pend_s  = mem_wen && hit && (offset_s == OFF_PENDING);
   assign wr_mask_s  = mem_wen && hit && (offset_s == OFF_MASK);
   assign wr_mode_s  = mem_wen && hit && (offset_s == OFF_MODE);
   assign claim_rd_s = mem_ren && hit && (offset_s == OFF_CLAIM);
   // A stalled CLAIM read keeps mem_ren high; only its first cycle claims.
   assign claim_s    = claim_rd_s && !claim_busy_r && (irq_id != 5'd0);
   assign rise_s     = s2_r & ~s3_r;
   assign active_s   = pending_r & mask_r;
   assign w1c_s      = wr_pend_s ? mem_wdata[N_SRC-1:0] : {N_SRC{1'b0}};

   // Per-source pending update: edge bits set on rise (set beats clear),
   // level bits simply follow the synchronized source.
   always_comb begin
      claim_clr_s   = {N_SRC{1'b0}};
      pending_nxt_s = {N_SRC{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         claim_clr_s[i] = claim_s && (irq_id == 5'(i + 1));
         if (mode_r[i]) begin
            pending_nxt_s[i] = rise_s[i] | (pending_r[i] & ~w1c_s[i] & ~claim_clr_s[i]);
         end else begin
            pending_nxt_s[i] = s2_r[i];
         end
      end
   end

   // Fixed-priority encoder: lowest active index wins, id is index+1.
   always_comb begin
      id_nxt_s = 5'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active_s[i]) begin
            id_nxt_s = 5'(i + 1);
         end else begin
            id_nxt_s = id_nxt_s;
         end
      end
   end

   // Read mux: combinational from register state, zero when not a hitting read.
   always_comb begin
      mem_rdata = 32'h0000_0000;
      if (mem_ren && hit) begin
         case (offset_s)
            OFF_PENDING: mem_rdata = zext(pending_r);
            OFF_MASK:    mem_rdata = zext(mask_r);
            OFF_MODE:    mem_rdata = zext(mode_r);
            OFF_CLAIM:   mem_rdata = {27'h000_0000, irq_id};
            default:     mem_rdata = 32'h0000_0000;
         endcase
      end else begin
         mem_rdata = 32'h0000_0000;
      end
   end

   // Three-stage source synchronizer; stages 2/3 feed the rise detector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_r <= {N_SRC{1'b0}};
         s2_r <= {N_SRC{1'b0}};
         s3_r <= {N_SRC{1'b0}};
      end else begin
         s1_r <= irq_src;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Software-visible registers and the claim stall tracker.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_r    <= {N_SRC{1'b0}};
         mask_r       <= {N_SRC{1'b0}};
         mode_r       <= {N_SRC{1'b0}};
         claim_busy_r <= 1'b0;
      end else begin
         pending_r    <= pending_nxt_s;
         claim_busy_r <= claim_rd_s;
         if (wr_mask_s) begin
            mask_r <= mem_wdata[N_SRC-1:0];
         end else begin
            mask_r <= mask_r;
         end
         if (wr_mode_s) begin
            mode_r <= mem_wdata[N_SRC-1:0];
         end else begin
            mode_r <= mode_r;
         end
      end
   end

   // Registered request and id toward CP0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         interrupter <= 1'b0;
         irq_id      <= 5'd0;
      end else begin
         interrupter <= |active_s;
         irq_id      <= id_nxt_s;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus pushes expected values into
// queues, a monitor pops and compares them on the following falling edge.

module tb_irq_controller;

   localparam logic [31:0] BASE    = 32'hFFFF_0100;
   localparam logic [31:0] A_PEND  = BASE;
   localparam logic [31:0] A_MASK  = BASE + 32'd4;
   localparam logic [31:0] A_MODE  = BASE + 32'd8;
   localparam logic [31:0] A_CLAIM = BASE + 32'd12;
   localparam int K_RDATA = 0;
   localparam int K_IRQ   = 1;
   localparam int K_ID    = 2;
   localparam int K_HIT   = 3;

   logic        clk;
   logic        rst;
   logic [7:0]  irq_src;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        hit, interrupter;
   logic [4:0]  irq_id;

   int          kind_q[$];
   string       name_q[$];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   irq_controller #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .irq_src(irq_src),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hit(hit),
      .interrupter(interrupter), .irq_id(irq_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every queued expectation is compared on the next falling edge.
   always @(negedge clk) begin
      int          k;
      string       nm;
      logic [31:0] ex, act;
      while (kind_q.size() > 0) begin
         k  = kind_q.pop_front();
         nm = name_q.pop_front();
         ex = exp_q.pop_front();
         case (k)
            K_RDATA: act = mem_rdata;
            K_IRQ:   act = {31'h0, interrupter};
            K_ID:    act = {27'h0, irq_id};
            default: act = {31'h0, hit};
         endcase
         n_checks++;
         if (act !== ex) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, ex);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input int k, input string nm, input logic [31:0] ex);
      kind_q.push_back(k);
      name_q.push_back(nm);
      exp_q.push_back(ex);
   endtask

   task automatic out_chk(input logic irq, input logic [4:0] id, input string nm);
      expect_val(K_IRQ, {nm, "_irq"}, {31'h0, irq});
      expect_val(K_ID,  {nm, "_id"},  {27'h0, id});
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      mem_addr  = a;
      mem_wdata = d;
      mem_wen   = 1'b1;
      tick();
      mem_wen   = 1'b0;
   endtask

   task automatic read_chk(input logic [31:0] a, input logic [31:0] ex, input string nm);
      mem_addr = a;
      mem_ren  = 1'b1;
      expect_val(K_RDATA, nm, ex);
      tick();
      mem_ren  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; irq_src = 8'h00; mem_ren = 1'b0; mem_wen = 1'b0;
      mem_addr = 32'h0; mem_wdata = 32'h0;
      tick(); tick();
      out_chk(1'b0, 5'd0, "reset_out");
      read_chk(A_PEND, 32'h0, "reset_pend");
      rst = 1'b1;

      // Reset mid-operation
      bus_write(A_MASK, 32'hFF);
      bus_write(A_MODE, 32'hFF);
      irq_src = 8'h08;
      tick(); tick(); tick();
      read_chk(A_PEND, 32'h08, "mid_pend_set");
      out_chk(1'b1, 5'd4, "mid_pre");
      tick();
      rst = 1'b0;
      out_chk(1'b0, 5'd0, "mid_async");
      read_chk(A_PEND, 32'h0, "mid_pend");
      read_chk(A_MASK, 32'h0, "mid_mask");
      read_chk(A_MODE, 32'h0, "mid_mode");
      irq_src = 8'h00;
      tick();
      rst = 1'b1;

      // Edge latency and claim
      bus_write(A_MODE, 32'h01);
      bus_write(A_MASK, 32'h01);
      irq_src = 8'h01;
      tick(); tick(); tick();
      out_chk(1'b0, 5'd0, "lat_e2");
      read_chk(A_PEND, 32'h01, "lat_pend_e2");
      out_chk(1'b1, 5'd1, "lat_e3");
      read_chk(A_CLAIM, 32'h1, "lat_claim");
      out_chk(1'b1, 5'd1, "lat_claim_e1");
      read_chk(A_PEND, 32'h0, "lat_claim_pend");
      out_chk(1'b0, 5'd0, "lat_claim_e2");
      irq_src = 8'h00;

      // Priority and mask
      bus_write(A_MODE, 32'hFF);
      bus_write(A_MASK, 32'hF0);
      irq_src = 8'h24;
      tick();
      irq_src = 8'h00;
      tick(); tick();
      read_chk(A_PEND, 32'h24, "pri_pend");
      out_chk(1'b1, 5'd6, "pri_masked");
      bus_write(A_MASK, 32'hFFFF_FFFF);
      tick();
      out_chk(1'b1, 5'd3, "pri_unmasked");
      read_chk(A_MASK, 32'hFF, "mask_zext");
      bus_write(A_PEND, 32'hFF);

      // Held claim across stall cycles
      irq_src = 8'h12;
      tick();
      irq_src = 8'h00;
      tick(); tick(); tick();
      out_chk(1'b1, 5'd2, "hold_pre");
      mem_addr = A_CLAIM;
      mem_ren  = 1'b1;
      expect_val(K_RDATA, "hold_c1", 32'h2);
      tick();
      expect_val(K_RDATA, "hold_c2", 32'h2);
      tick();
      expect_val(K_RDATA, "hold_c3", 32'h5);
      tick();
      mem_ren = 1'b0;
      read_chk(A_PEND, 32'h10, "hold_pend");
      out_chk(1'b1, 5'd5, "hold_post");
      bus_write(A_PEND, 32'hFF);

      // W1C versus a new rising edge in the same cycle
      irq_src = 8'h08;
      tick();
      irq_src = 8'h00;
      tick(); tick();
      irq_src = 8'h08;
      tick(); tick();
      bus_write(A_PEND, 32'h08);
      irq_src = 8'h00;
      read_chk(A_PEND, 32'h08, "w1c_vs_rise");
      bus_write(A_PEND, 32'h08);
      read_chk(A_PEND, 32'h00, "w1c_plain");

      // Level source ignores W1C
      bus_write(A_MODE, 32'hBF);
      irq_src = 8'h40;
      tick(); tick(); tick();
      read_chk(A_PEND, 32'h40, "lvl_set");
      bus_write(A_PEND, 32'h40);
      read_chk(A_PEND, 32'h40, "lvl_w1c");
      out_chk(1'b1, 5'd7, "lvl_out");
      irq_src = 8'h00;
      tick(); tick(); tick();
      read_chk(A_PEND, 32'h00, "lvl_fall");

      // Address decode
      mem_addr  = BASE + 32'h10;
      mem_wdata = 32'hFFFF_FFFF;
      mem_wen   = 1'b1;
      expect_val(K_HIT, "oow_hit", 32'h0);
      tick();
      mem_wen = 1'b0;
      read_chk(BASE + 32'h10, 32'h0, "oow_rdata");
      mem_addr = A_CLAIM;
      expect_val(K_HIT, "in_hit", 32'h1);
      tick();
      bus_write(A_CLAIM, 32'hFFFF_FFFF);
      read_chk(BASE + 32'h6, 32'hFF, "mask_unaligned");
      read_chk(A_MODE, 32'hBF, "mode_keep");
      read_chk(A_PEND, 32'h00, "pend_keep");

      // Simultaneous read and write returns pre-write data
      mem_addr  = A_MASK;
      mem_wdata = 32'h0F;
      mem_wen   = 1'b1;
      mem_ren   = 1'b1;
      expect_val(K_RDATA, "rw_pre", 32'hFF);
      tick();
      mem_wen = 1'b0;
      mem_ren = 1'b0;
      read_chk(A_MASK, 32'h0F, "rw_post");

      tick(); tick();
      if (kind_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", kind_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
